nandn_xreg_xfreq: RTL
=====================

Name: nandn_xreg_xfreq

Overview:
Parametrised successor to the single-gate 2-input NAND brick. Provides CH independent NIN-input NAND channels with a registered output. A programmable tick prescaler (XFREQ) sets the update rate, and a loop mode (XLOOP) feeds each output back onto its own input 0, so the cell acts as a divided toggle source. It sits in generated brick arrays as a clocked logic/clock-divider primitive. CELV/CELG/SUB are carried as supply pins for the analog view and have no logical function.

Parameters:
NIN, 2, inputs per NAND channel (2..8)
CH, 1, number of independent channels (1..32)
DIV_W, 8, width of prescaler divide value

Ports:
CELCLK  input  1  clock; all state updates on rising edge
CELRST  input  1  synchronous reset, active-high
CELV  input  1  supply pin, no logic function
CELG  input  1  ground pin, no logic function
SUB  input  1  substrate pin, no logic function
i  input  CH*NIN  channel inputs; channel c uses bits [c*NIN +: NIN]
en  input  1  run enable
mode  input  1  0 = REG (registered NAND), 1 = LOOP (feedback toggle)
div  input  DIV_W  prescaler value; tick every div+1 RUN cycles
o  output  CH  registered NAND outputs
o_vld  output  1  one-cycle pulse in the cycle after o updated
busy  output  1  high in ARM and RUN

Behaviour:
- Reset (CELRST=1 at an edge): state=IDLE, o={CH{1'b1}}, o_vld=0, cnt=0, div_q=0, mode_q=0. Reset overrides all other inputs, including in the middle of a run.
- FSM states: IDLE, ARM, RUN.
  - IDLE: o holds its value, o_vld=0. en=1 -> ARM.
  - ARM (exactly 1 cycle): capture div_q<=div and mode_q<=mode, set cnt<=0, then go to RUN. en=0 during ARM -> IDLE.
  - RUN: cnt increments each cycle. tick = (cnt==div_q). On a tick, cnt<=0.
  - RUN, en=0 -> IDLE at the next edge. o holds its value and no tick occurs in that cycle.
  - RUN, mode!=mode_q -> ARM. The counter restarts and o holds its value. Changes to div during RUN are ignored until the next ARM.
- Tick timing: the first tick falls in RUN cycle div_q+1, counting the first RUN cycle as 1. div=0 ticks every RUN cycle; div=2^DIV_W-1 ticks every 2^DIV_W cycles. cnt never exceeds div_q.
- Update on a tick edge, per channel c:
  - REG: o[c] <= ~&i[c*NIN +: NIN]. Inputs are sampled in the tick cycle, so latency is 1 edge.
  - LOOP: o[c] <= ~(o[c] & (&i[c*NIN+1 +: NIN-1])). Input bit 0 is ignored. With the other inputs all high, o toggles each tick, giving period 2*(div_q+1). If any other input is low, o is forced to 1.
- o_vld: registered, equal to 1 for exactly the cycle after each tick edge; otherwise 0. It is 0 in IDLE and ARM.
- busy = (state!=IDLE), combinational from the state register.
- Simultaneous events: CELRST beats en=0, and en=0 beats a mode change. If en falls in a tick cycle, no update happens.
- Supply pins are not used in the logic.

Test Plan:
- Reset: CELRST=1 for 2 cycles with en=1 and i all 0 -> o=all 1, o_vld=0, busy=0. Release, hold en=1 -> busy=1 on the next cycle (ARM).
- REG, CH=2, NIN=2, div=0: i=4'b0111 -> after ARM, first RUN edge gives o=2'b10 and o_vld=1 one cycle later. Change i to 4'b1111 -> o=2'b00 on the next edge.
- Prescale, div=3, REG: o_vld pulses exactly every 4 cycles. Changing div to 1 mid-RUN has no effect; rate changes only after an en low/high re-arm.
- LOOP, CH=1, NIN=3, div=1, i=3'b110 -> o toggles 1,0,1,0 with period 4 cycles. Set i[1]=0 -> o=1 at the next tick and stays 1.
- Mode switch in RUN (REG->LOOP) -> one ARM cycle (busy stays 1), cnt restarts, first LOOP tick div+1 cycles later.
- Reset mid-RUN with div=5 and cnt=3 -> next cycle: state IDLE, o=all 1, o_vld=0, no spurious tick.

Source files
------------

// File: rtl/nandn_xreg_xfreq_if.sv
// Channel-input / registered-output bundle for the clocked NAND brick.
// Latency: none (wires only).
// Backpressure: none; o_vld is a pulse, busy is a level.
interface nandn_xreg_xfreq_if #(
    parameter int NIN   = 2,
    parameter int CH    = 1,
    parameter int DIV_W = 8
);
    logic [CH*NIN-1:0] i;
    logic              en;
    logic              mode;
    logic [DIV_W-1:0]  div;
    logic [CH-1:0]     o;
    logic              o_vld;
    logic              busy;

    // Stimulus side drives the controls, the brick drives the results
    modport master (output i, en, mode, div, input o, o_vld, busy);
    modport slave  (input i, en, mode, div, output o, o_vld, busy);
endinterface

// File: rtl/nandn_xreg_xfreq.sv
// CH independent NIN-input NAND channels, output updated on a prescaled tick, optional feedback toggle.
// Latency: first update div+1 RUN cycles after ARM; o_vld follows each update by one cycle.
// Backpressure: none; en low parks the cell in IDLE, a mode change re-arms it.
module nandn_xreg_xfreq #(
    parameter int NIN   = 2,
    parameter int CH    = 1,
    parameter int DIV_W = 8
) (
    input  logic              CELCLK,
    input  logic              CELRST,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    nandn_xreg_xfreq_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic             r_mode_q;
    logic [CH-1:0]    r_o;
    logic [CH-1:0]    w_o_nxt;
    logic             r_o_vld;
    logic             w_tick;

    // Supply pins exist only for the analog view
    logic w_unused_supply;
    assign w_unused_supply = CELV ^ CELG ^ SUB;

    // Next state and tick; en low outranks a mode change, both suppress the tick
    always_comb begin
        w_next = r_state;
        w_tick = 1'b0;
        case (r_state)
            S_IDLE: if (bus.en) w_next = S_ARM;
            S_ARM:  w_next = bus.en ? S_RUN : S_IDLE;
            S_RUN: begin
                if (!bus.en) begin
                    w_next = S_IDLE;
                end else if (bus.mode != r_mode_q) begin
                    w_next = S_ARM;
                end else begin
                    w_tick = (r_cnt == r_div_q);
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Per-channel NAND result; in loop mode input bit 0 is replaced by the channel's own output
    always_comb begin
        w_o_nxt = r_o;
        for (int c = 0; c < CH; c++) begin
            if (r_mode_q) begin
                w_o_nxt[c] = ~(r_o[c] & (&bus.i[c*NIN+1 +: NIN-1]));
            end else begin
                w_o_nxt[c] = ~(&bus.i[c*NIN +: NIN]);
            end
        end
    end

    // State, prescaler, captured config and output registers
    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div_q  <= '0;
            r_mode_q <= 1'b0;
            r_o      <= {CH{1'b1}};
            r_o_vld  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_o_vld <= w_tick;
            case (r_state)
                S_ARM: begin
                    r_div_q  <= bus.div;
                    r_mode_q <= bus.mode;
                    r_cnt    <= '0;
                end
                S_RUN: begin
                    // Counter only advances while staying in RUN, so it never passes div_q
                    if (w_next != S_RUN || w_tick) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                    if (w_tick) r_o <= w_o_nxt;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.o     = r_o;
    assign bus.o_vld = r_o_vld;
    assign bus.busy  = (r_state != S_IDLE);

endmodule
